// File: rtl/deserializer_out.sv
// deserializer_out
// Receive end of the 9-bit-word serial link. Hunts for the K-code comma to
// recover word alignment, confirms LOCK_CNT consecutive commas in slot 0, then
// delivers the three data bytes after each comma as one 24-bit word.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   data_i, sample_i  serial bit and its qualifier (bit consumed when sample_i=1)
//   data_o            last packet {byte3, byte2, byte1}
//   valid_o           one-cycle strobe, data_o updated
//   locked_o          alignment established
//   err_o             one-cycle strobe, framing error while locked
//   cnt_pkt_o         current word slot (0 = comma, 1..3 = data)
//   pkt_cnt_o, err_cnt_o  saturating statistics, only with DESERIALIZER_OUT_STATS_EN
//
// Optional feature macro: DESERIALIZER_OUT_STATS_EN
//
// state     | meaning
// ST_HUNT   | searching every cycle for the comma word in the shift register
// ST_ALIGN  | word aligned, counting consecutive commas in slot 0
// ST_LOCKED | lock declared, packets delivered
module deserializer_out #(
  parameter logic [7:0]  COMMA    = 8'h3C,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  input  logic        sample_i,
  output logic [23:0] data_o,
  output logic        valid_o,
  output logic        locked_o,
  output logic        err_o,
  output logic [1:0]  cnt_pkt_o
`ifdef DESERIALIZER_OUT_STATS_EN
  ,
  output logic [15:0] pkt_cnt_o,
  output logic [7:0]  err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [8:0] COMMA_WORD = {1'b1, COMMA};
  localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_sr;
  logic [3:0]  r_bit_cnt;
  logic [1:0]  r_slot;
  logic [3:0]  r_good_cnt;
  logic        r_word_done;
  logic [7:0]  r_b1;
  logic [7:0]  r_b2;
  logic [23:0] r_data;
  logic        r_valid;
  logic        r_err;

  logic w_is_comma;
  logic w_frame_bad;
  logic w_comma_hit;
  logic w_good_last;
  logic w_valid_nxt;
  logic w_err_nxt;

  // r_word_done marks the cycle after the 9th bit landed, so r_sr holds the
  // complete word and r_slot still names the slot it belongs to.
  assign w_is_comma  = (r_sr == COMMA_WORD);
  assign w_comma_hit = r_word_done && (r_slot == 2'd0) && w_is_comma;
  assign w_frame_bad = r_word_done &&
                       (((r_slot == 2'd0) && !w_is_comma) ||
                        ((r_slot != 2'd0) && r_sr[8]));
  assign w_good_last = ((r_good_cnt + 4'd1) == LOCK_CNT_L);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_HUNT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_HUNT:
        if (w_is_comma) w_state_nxt = (LOCK_CNT_L == 4'd1) ? ST_LOCKED : ST_ALIGN;
      ST_ALIGN:
        if (w_frame_bad)                     w_state_nxt = ST_HUNT;
        else if (w_comma_hit && w_good_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED:
        if (w_frame_bad) w_state_nxt = ST_HUNT;
      default:
        w_state_nxt = ST_HUNT;
    endcase
  end

  // Output logic
  always_comb begin
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    locked_o    = (r_state == ST_LOCKED);
    cnt_pkt_o   = (r_state == ST_HUNT) ? 2'd0 : r_slot;
    if ((r_state == ST_LOCKED) && r_word_done) begin
      if (w_frame_bad)            w_err_nxt   = 1'b1;
      else if (r_slot == 2'd3)    w_valid_nxt = 1'b1;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign err_o   = r_err;

  // Datapath: shift register, bit/slot/comma counters, packet assembly
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_slot      <= '0;
      r_good_cnt  <= '0;
      r_word_done <= 1'b0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
      r_word_done <= 1'b0;
      if (sample_i) r_sr <= {data_i, r_sr[8:1]};

      if (r_state == ST_HUNT) begin
        if (w_is_comma) begin
          // A bit sampled in the detection cycle is already the first bit
          // of the slot-1 word, so it must be counted.
          r_bit_cnt  <= sample_i ? 4'd1 : 4'd0;
          r_slot     <= 2'd1;
          r_good_cnt <= 4'd1;
        end
      end else if (w_state_nxt == ST_HUNT) begin
        r_bit_cnt  <= '0;
        r_slot     <= '0;
        r_good_cnt <= '0;
      end else begin
        if (sample_i) begin
          r_bit_cnt   <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
          r_word_done <= (r_bit_cnt == 4'd8);
        end
        if (r_word_done) begin
          r_slot <= r_slot + 2'd1;
          if ((r_state == ST_ALIGN) && w_comma_hit) r_good_cnt <= r_good_cnt + 4'd1;
          if (r_state == ST_LOCKED) begin
            unique case (r_slot)
              2'd1:    r_b1   <= r_sr[7:0];
              2'd2:    r_b2   <= r_sr[7:0];
              2'd3:    r_data <= {r_sr[7:0], r_b2, r_b1};
              default: ;
            endcase
          end
        end
      end
    end
  end

`ifdef DESERIALIZER_OUT_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_valid && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (r_err   && (r_err_cnt != 8'hFF))    r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign pkt_cnt_o = r_pkt_cnt;
  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_deserializer_out.sv
module tb_deserializer_out;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_i = 1'b0;
  logic        sample_i = 1'b0;
  logic [23:0] data_o;
  logic        valid_o;
  logic        locked_o;
  logic        err_o;
  logic [1:0]  cnt_pkt_o;
`ifdef DESERIALIZER_OUT_STATS_EN
  logic [15:0] pkt_cnt_o;
  logic [7:0]  err_cnt_o;
`endif

  deserializer_out dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .sample_i  (sample_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .cnt_pkt_o (cnt_pkt_o)
`ifdef DESERIALIZER_OUT_STATS_EN
    ,
    .pkt_cnt_o (pkt_cnt_o),
    .err_cnt_o (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  localparam logic [8:0] C9 = 9'h13C;

  typedef struct {
    bit          is_err;
    logic [23:0] data;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_valid(input logic [23:0] d, input int gap);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [23:0] d);
    exp_t e;
    e.is_err = 1'b1; e.data = d; e.gap = 0;
    exp_q.push_back(e);
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor: pops one expectation per strobe
  always @(posedge clk_i) begin
    #1;
    if (valid_o && err_o) chk("both_strobes", 32'd1, 32'd0);
    if (valid_o || err_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {31'd0, err_o}, 32'hFFFF_FFFF);
      end else begin
        e_cur = exp_q.pop_front();
        chk("strobe_kind", {31'd0, err_o}, {31'd0, e_cur.is_err});
        chk("data_o", {8'd0, data_o}, {8'd0, e_cur.data});
        if (e_cur.is_err) begin
          chk("err_locked", {31'd0, locked_o}, 32'd0);
          chk("err_cnt_pkt", {30'd0, cnt_pkt_o}, 32'd0);
        end else if (e_cur.gap != 0) begin
          chk("valid_gap", 32'(cyc - last_valid_cyc), 32'(e_cur.gap));
        end
      end
      if (valid_o) last_valid_cyc = cyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      sample_i = 1'b0;
      data_i   = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(4);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] w, input bit toggle);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      data_i   = w[i];
      sample_i = 1'b1;
      if (toggle) begin
        @(negedge clk_i);
        data_i   = ~w[i];
        sample_i = 1'b0;
      end
    end
  endtask

  task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input bit toggle);
    send_word(C9, toggle);
    send_word({1'b0, b1}, toggle);
    send_word({1'b0, b2}, toggle);
    send_word({1'b0, b3}, toggle);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_data_o",   {8'd0, data_o},      32'd0);
    chk("rst_valid_o",  {31'd0, valid_o},    32'd0);
    chk("rst_locked_o", {31'd0, locked_o},   32'd0);
    chk("rst_err_o",    {31'd0, err_o},      32'd0);
    chk("rst_cnt_pkt",  {30'd0, cnt_pkt_o},  32'd0);
    do_reset();

    // Continuous stream: lock after 2nd comma, two packets
    send_word(C9, 0);
    send_word(9'h011, 0);
    send_word(9'h022, 0);
    send_word(9'h033, 0);
    chk("t1_unlocked",  {31'd0, locked_o},  32'd0);
    chk("t1_slot3",     {30'd0, cnt_pkt_o}, 32'd3);
    push_valid(24'hCCBBAA, 0);
    send_word(C9, 0);
    send_word(9'h0AA, 0);
    chk("t1_locked",    {31'd0, locked_o},  32'd1);
    chk("t1_slot1",     {30'd0, cnt_pkt_o}, 32'd1);
    send_word(9'h0BB, 0);
    send_word(9'h0CC, 0);
    push_valid(24'h030201, 36);
    send_pkt(8'h01, 8'h02, 8'h03, 0);
    @(posedge clk_i);
    #1;
    sample_i = 1'b0;
    chk("t1_lat_p0", {31'd0, valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    chk("t1_lat_p1", {31'd0, valid_o}, 32'd1);
    do_reset();

    // Garbage bits ahead of the first comma
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      data_i   = (i == 1 || i == 4) ? 1'b0 : 1'b1;
      sample_i = 1'b1;
    end
    push_valid(24'hCCBBAA, 0);
    send_pkt(8'h11, 8'h22, 8'h33, 0);
    send_pkt(8'hAA, 8'hBB, 8'hCC, 0);
    push_valid(24'h030201, 36);
    send_pkt(8'h01, 8'h02, 8'h03, 0);
    do_reset();

    // k=1 in slot 2 while locked, then relock
    push_valid(24'hCCBBAA, 0);
    send_pkt(8'h11, 8'h22, 8'h33, 0);
    send_pkt(8'hAA, 8'hBB, 8'hCC, 0);
    push_err(24'hCCBBAA);
    send_word(C9, 0);
    send_word(9'h044, 0);
    send_word(9'h155, 0);
    send_word(9'h066, 0);
    chk("t3_unlocked", {31'd0, locked_o}, 32'd0);
    send_pkt(8'h77, 8'h88, 8'h99, 0);
    chk("t3_relock_pending", {31'd0, locked_o}, 32'd0);
    push_valid(24'hC3B2A1, 0);
    send_word(C9, 0);
    send_word(9'h0A1, 0);
    chk("t3_relocked", {31'd0, locked_o}, 32'd1);
    send_word(9'h0B2, 0);
    send_word(9'h0C3, 0);
    do_reset();

    // Slot 0 carries a non-comma while locked
    push_valid(24'hCCBBAA, 0);
    send_pkt(8'h11, 8'h22, 8'h33, 0);
    send_pkt(8'hAA, 8'hBB, 8'hCC, 0);
    push_err(24'hCCBBAA);
    send_word(9'h0BC, 0);
    send_word(9'h001, 0);
    send_word(9'h002, 0);
    send_word(9'h003, 0);
    chk("t4_cnt_pkt", {30'd0, cnt_pkt_o}, 32'd0);
    chk("t4_unlocked", {31'd0, locked_o}, 32'd0);
    chk("t4_data_hold", {8'd0, data_o}, 32'h00CCBBAA);
    do_reset();

    // sample_i toggling every cycle
    push_valid(24'hCCBBAA, 0);
    send_pkt(8'h11, 8'h22, 8'h33, 1);
    send_pkt(8'hAA, 8'hBB, 8'hCC, 1);
    push_valid(24'h030201, 72);
    send_pkt(8'h01, 8'h02, 8'h03, 1);
    do_reset();

    // Asynchronous reset in the middle of byte 2
    push_valid(24'hCCBBAA, 0);
    send_pkt(8'h11, 8'h22, 8'h33, 0);
    send_pkt(8'hAA, 8'hBB, 8'hCC, 0);
    send_word(C9, 0);
    send_word(9'h001, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      data_i   = (i == 1);
      sample_i = 1'b1;
    end
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_data_o",   {8'd0, data_o},     32'd0);
    chk("t6_locked_o", {31'd0, locked_o},  32'd0);
    chk("t6_valid_o",  {31'd0, valid_o},   32'd0);
    chk("t6_err_o",    {31'd0, err_o},     32'd0);
    chk("t6_cnt_pkt",  {30'd0, cnt_pkt_o}, 32'd0);
    do_reset();
    send_pkt(8'h12, 8'h34, 8'h56, 0);
    chk("t6_relock_pending", {31'd0, locked_o}, 32'd0);
    push_valid(24'hDEBC9A, 0);
    send_pkt(8'h9A, 8'hBC, 8'hDE, 0);
    do_reset();

    // Three good packets and one framing error
`ifdef DESERIALIZER_OUT_STATS_EN
    chk("stats_rst_pkt", {16'd0, pkt_cnt_o}, 32'd0);
    chk("stats_rst_err", {24'd0, err_cnt_o}, 32'd0);
`endif
    push_valid(24'hCCBBAA, 0);
    send_pkt(8'h11, 8'h22, 8'h33, 0);
    send_pkt(8'hAA, 8'hBB, 8'hCC, 0);
    push_valid(24'h030201, 36);
    send_pkt(8'h01, 8'h02, 8'h03, 0);
    push_valid(24'h665544, 36);
    send_pkt(8'h44, 8'h55, 8'h66, 0);
    push_err(24'h665544);
    send_word(9'h0BC, 0);
    idle(6);
`ifdef DESERIALIZER_OUT_STATS_EN
    chk("stats_pkt_cnt", {16'd0, pkt_cnt_o}, 32'd3);
    chk("stats_err_cnt", {24'd0, err_cnt_o}, 32'd1);
`endif

    idle(4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
